// File: rtl/hdmi_island_pkg.sv
// Shared HDMI data island definitions: FSM state encoding, period lengths and
// the blanking thresholds needed to fit an island before the next video preamble.
package hdmi_island_pkg;

  typedef enum logic [2:0] {
    ST_CONTROL,
    ST_PREAMBLE,
    ST_LEAD_GUARD,
    ST_PACKET,
    ST_TRAIL_GUARD
  } island_state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  // Blanking needed at the START decision: whole island (one packet) plus the
  // mandatory control run, plus the decision cycle itself.
  function automatic int start_min(input int min_control);
    return PREAMBLE_LEN + GUARD_LEN + PACKET_LEN + GUARD_LEN + min_control + 1;
  endfunction

  // Blanking needed at a packet's last pixel to append one more packet.
  function automatic int cont_min(input int min_control);
    return PACKET_LEN + GUARD_LEN + min_control + 1;
  endfunction

endpackage

// File: rtl/data_island_scheduler.sv
// Schedules HDMI data islands inside blanking: preamble, guards, packet bodies,
// packet_enable strobes to the picker, and a sticky error if video lands mid-island.
module data_island_scheduler
  import hdmi_island_pkg::*;
#(
  parameter bit DVI_OUTPUT  = 1'b0,
  parameter int MAX_PACKETS = 18,
  parameter int MIN_CONTROL = 4,
  parameter int BLANK_WIDTH = 12
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   video_data_period,
  input  logic [BLANK_WIDTH-1:0] blank_cycles_remaining,
  input  logic                   packet_pending,
  output logic                   data_island_preamble,
  output logic                   data_island_guard,
  output logic                   data_island_period,
  output logic                   packet_enable,
  output logic [4:0]             packet_pixel_counter,
  output logic                   schedule_error
);

  localparam int CW = (MIN_CONTROL > 0) ? $clog2(MIN_CONTROL + 1) : 1;
  localparam int PW = $clog2(MAX_PACKETS + 1);

  localparam logic [BLANK_WIDTH-1:0] START_MIN = BLANK_WIDTH'(start_min(MIN_CONTROL));
  localparam logic [BLANK_WIDTH-1:0] CONT_MIN  = BLANK_WIDTH'(cont_min(MIN_CONTROL));
  localparam logic [CW-1:0]          CTRL_SAT  = CW'(MIN_CONTROL);
  localparam logic [PW-1:0]          PKT_MAX   = PW'(MAX_PACKETS);
  localparam logic [4:0]             PRE_LAST  = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]             GRD_LAST  = 5'(GUARD_LEN - 1);
  localparam logic [4:0]             PKT_LAST  = 5'(PACKET_LEN - 1);

  island_state_t state, state_next;
  logic [4:0]    cnt;
  logic [CW-1:0] ctrl_cnt;
  logic [PW-1:0] pkt_cnt;
  logic          sched_err_q;
  logic          pkt_start, pkt_continue, abort;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= ST_CONTROL;
      cnt         <= '0;
      ctrl_cnt    <= '0;
      pkt_cnt     <= '0;
      sched_err_q <= 1'b0;
    end else begin
      state <= state_next;
      // Back-to-back packets keep state PACKET; cnt wraps 31->0 on its own.
      if (state_next != state || state_next == ST_CONTROL) cnt <= '0;
      else                                                 cnt <= cnt + 5'd1;

      if (state != ST_CONTROL || video_data_period) ctrl_cnt <= '0;
      else if (ctrl_cnt != CTRL_SAT)                ctrl_cnt <= ctrl_cnt + CW'(1);

      if (state_next == ST_CONTROL) pkt_cnt <= '0;
      else if (pkt_start)           pkt_cnt <= PW'(1);
      else if (pkt_continue)        pkt_cnt <= pkt_cnt + PW'(1);

      if (abort) sched_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    pkt_start    = 1'b0;
    pkt_continue = 1'b0;
    abort        = 1'b0;
    if (!DVI_OUTPUT) begin
      unique case (state)
        ST_CONTROL:
          if (ctrl_cnt == CTRL_SAT && packet_pending && !video_data_period &&
              blank_cycles_remaining >= START_MIN)
            state_next = ST_PREAMBLE;
        ST_PREAMBLE:
          if (cnt == PRE_LAST) state_next = ST_LEAD_GUARD;
        ST_LEAD_GUARD:
          if (cnt == GRD_LAST) begin
            state_next = ST_PACKET;
            pkt_start  = 1'b1;
          end
        ST_PACKET:
          if (cnt == PKT_LAST) begin
            if (packet_pending && pkt_cnt < PKT_MAX && blank_cycles_remaining >= CONT_MIN)
              pkt_continue = 1'b1;
            else
              state_next = ST_TRAIL_GUARD;
          end
        ST_TRAIL_GUARD:
          if (cnt == GRD_LAST) state_next = ST_CONTROL;
        default: state_next = ST_CONTROL;
      endcase
      // Video inside an island is a timing violation: drop out and flag it.
      if (video_data_period && state != ST_CONTROL) begin
        state_next   = ST_CONTROL;
        pkt_start    = 1'b0;
        pkt_continue = 1'b0;
        abort        = 1'b1;
      end
    end
  end

  always_comb begin
    data_island_preamble = (state == ST_PREAMBLE);
    data_island_guard    = (state == ST_LEAD_GUARD) || (state == ST_TRAIL_GUARD);
    data_island_period   = (state == ST_PACKET);
    packet_enable        = (pkt_start || pkt_continue) && !reset;
    packet_pixel_counter = (state == ST_PACKET) ? cnt : 5'd0;
  end

  assign schedule_error = sched_err_q;

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: an island-position model checks every
// cycle, plus literal counts/timings per scenario; a DVI build must stay idle.
module tb_data_island_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1, video = 1'b0, pending = 1'b0;
  logic [11:0] rem = 12'd0;

  logic       pre, grd, per, pe, err;
  logic [4:0] pix;
  logic       d_pre, d_grd, d_per, d_pe, d_err;
  logic [4:0] d_pix;

  data_island_scheduler dut (
    .clk_pixel(clk_pixel), .reset(reset), .video_data_period(video),
    .blank_cycles_remaining(rem), .packet_pending(pending),
    .data_island_preamble(pre), .data_island_guard(grd), .data_island_period(per),
    .packet_enable(pe), .packet_pixel_counter(pix), .schedule_error(err));

  data_island_scheduler #(.DVI_OUTPUT(1'b1)) dut_dvi (
    .clk_pixel(clk_pixel), .reset(reset), .video_data_period(video),
    .blank_cycles_remaining(rem), .packet_pending(pending),
    .data_island_preamble(d_pre), .data_island_guard(d_grd), .data_island_period(d_per),
    .packet_enable(d_pe), .packet_pixel_counter(d_pix), .schedule_error(d_err));

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0, failures = 0;
  // Model: position within the current island and how many packets are committed.
  bit m_valid = 0, m_isl = 0, m_err = 0;
  int m_pos = 0, m_npk = 0, m_quiet = 0;
  // Observations of the DUT outputs.
  int cyc = 0, n_pre = 0, n_grd = 0, n_per = 0, n_pe = 0, n_pe_per = 0, n_starts = 0;
  int pre_start_cyc = -1, last_grd_cyc = -1, last_grd_rem = -1, gap = -1;
  logic prev_pre = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    bit e_pre, e_grd, e_per, e_pe;
    int e_pix, plen;
    cyc++;
    e_pre = 0; e_grd = 0; e_per = 0; e_pe = 0; e_pix = 0;
    if (m_valid && !reset) begin
      chk("dvi_idle", int'({d_pre, d_grd, d_per, d_pe, d_pix, d_err}), 0);
      if (m_isl) begin
        plen  = 10 + 32 * m_npk;
        e_pre = m_pos < 8;
        e_grd = (m_pos >= 8 && m_pos < 10) || m_pos >= plen;
        e_per = m_pos >= 10 && m_pos < plen;
        e_pix = e_per ? (m_pos - 10) % 32 : 0;
        if (!video)
          e_pe = (m_pos == 9) ||
                 (e_per && e_pix == 31 && pending && m_npk < 18 && int'(rem) >= 39);
      end
      chk("preamble", int'(pre), int'(e_pre));
      chk("guard", int'(grd), int'(e_grd));
      chk("period", int'(per), int'(e_per));
      chk("packet_enable", int'(pe), int'(e_pe));
      chk("pixel_counter", int'(pix), e_pix);
      chk("schedule_error", int'(err), int'(m_err));
      if (pre) n_pre++;
      if (per) n_per++;
      if (pe) n_pe++;
      if (pe && per) n_pe_per++;
      if (grd) begin n_grd++; last_grd_cyc = cyc; last_grd_rem = int'(rem); end
      if (pre && !prev_pre) begin
        n_starts++; pre_start_cyc = cyc; gap = cyc - last_grd_cyc - 1;
      end
      prev_pre = pre;
    end
    if (reset) begin
      m_valid = 1; m_isl = 0; m_quiet = 0; m_err = 0; prev_pre = 1'b0;
    end else if (m_valid) begin
      if (m_isl) begin
        if (video) begin m_isl = 0; m_err = 1; m_quiet = 0; end
        else begin
          if (e_pe) m_npk++;
          m_pos++;
          if (m_pos >= 10 + 32 * m_npk + 2) begin m_isl = 0; m_quiet = 0; end
        end
      end else if (video) m_quiet = 0;
      else if (m_quiet >= 4 && pending && int'(rem) >= 49) begin
        m_isl = 1; m_pos = 0; m_npk = 0;
      end else if (m_quiet < 4) m_quiet++;
    end
  endtask

  // Evaluate the current cycle mid-period, then advance; inputs change just after posedge.
  task automatic step();
    @(negedge clk_pixel);
    monitor();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Returns right after the first preamble cycle has been evaluated.
  task automatic wait_island(input string name, input int bound);
    int s, i;
    s = n_starts; i = 0;
    while (n_starts == s && i < bound) begin step(); i++; end
    chk(name, n_starts - s, 1);
  endtask

  int b_pre, b_grd, b_per, b_pe, b_pe_per, b_st, c0;

  task automatic snap();
    b_pre = n_pre; b_grd = n_grd; b_per = n_per; b_pe = n_pe; b_pe_per = n_pe_per; b_st = n_starts;
  endtask

  initial begin
    // 1: first island after reset, single packet
    reset = 1; pending = 1; rem = 12'd200;
    @(posedge clk_pixel); #1;
    run(5);
    reset = 0;
    c0 = cyc + 1;
    snap();
    wait_island("t1_start", 20);
    chk("t1_start_cycle", pre_start_cyc - c0, 5);
    pending = 0;
    run(50);
    chk("t1_preamble_cycles", n_pre - b_pre, 8);
    chk("t1_guard_cycles", n_grd - b_grd, 4);
    chk("t1_period_cycles", n_per - b_per, 32);
    chk("t1_enables", n_pe - b_pe, 1);

    // 2: START threshold 48 vs 49, then control run before the video preamble
    pending = 1; rem = 12'd48;
    snap();
    run(20);
    chk("t2_rem48_no_start", n_starts - b_st, 0);
    rem = 12'd49;
    for (int i = 0; i < 49; i++) begin step(); rem = rem - 12'd1; end
    chk("t2_rem49_start", n_starts - b_st, 1);
    chk("t2_last_guard_rem", last_grd_rem, 5);

    // 3: full island of 18 packets, then the control gap before the next one
    rem = 12'd1000;
    wait_island("t3_start", 20);
    snap();
    wait_island("t3_next_start", 700);
    chk("t3_period_cycles", n_per - b_per, 576);
    chk("t3_mid_enables", n_pe_per - b_pe_per, 17);
    chk("t3_enables", n_pe - b_pe, 18);
    chk("t3_control_gap", gap, 5);
    pending = 0;
    run(60);

    // 4: continuation threshold 38 vs 39
    pending = 1; rem = 12'd200;
    wait_island("t4a_start", 20);
    snap();
    rem = 12'd38;
    run(60);
    chk("t4a_period_cycles", n_per - b_per, 32);
    rem = 12'd200;
    wait_island("t4b_start", 20);
    snap();
    rem = 12'd39;
    run(41);
    pending = 0;
    run(60);
    chk("t4b_period_cycles", n_per - b_per, 64);
    chk("t4b_enables", n_pe - b_pe, 2);

    // 5: video at packet cnt 10 aborts; error sticks until reset
    pending = 1; rem = 12'd200;
    wait_island("t5_start", 20);
    run(19);
    video = 1;
    step();
    video = 0; pending = 0;
    chk("t5_abort_period", int'(per), 0);
    chk("t5_abort_error", int'(err), 1);
    run(10);
    chk("t5_error_sticky", int'(err), 1);
    reset = 1;
    step();
    reset = 0;
    chk("t5_error_cleared", int'(err), 0);

    // 6: reset mid-packet clears everything next cycle
    pending = 1; rem = 12'd200;
    wait_island("t6_start", 20);
    run(14);
    reset = 1;
    step();
    chk("t6_outputs_after_reset", int'({pre, grd, per, pe, pix, err}), 0);
    reset = 0; pending = 0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
